// File: rtl/racetrack_port_arbiter.sv
// racetrack_port_arbiter
// Shares the racetrack logic-in-memory macro between the instruction-fetch
// port and the data/LiM port. The winner of a round-robin choice gets
// exactly one access on the macro controller port: a one-cycle start pulse,
// request fields held stable, then a wait for completion. A watchdog ends
// accesses that never complete with an error response. The read data goes
// back to the owning requester with a one-cycle rvalid.

module racetrack_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 22,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    // instruction-fetch port
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,

    // data / LiM port
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [7:0]            data_funct_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,

    // response qualifier
    output logic                  err_o,

    // macro controller port
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [7:0]            mem_funct_o,
    input  logic                  mem_done_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  busy_o
);

    // LiM function code used for plain fetch accesses
    localparam logic [7:0] FUNCT_NULL = 8'h00;

    // arbiter states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // owner / round-robin pointer encoding
    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] WD_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 owner_q;
    logic                 last_q;
    logic [CNT_WIDTH-1:0] wd_q;
    logic                 err_q;
    logic [DATA_WIDTH-1:0] instr_rdata_q;
    logic [DATA_WIDTH-1:0] data_rdata_q;

    logic                  we_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            funct_q;

    logic pick_instr;
    logic pick_data;
    logic wait_done;
    logic wait_timeout;

    // Grant selection: only in IDLE and never while reset is applied, so
    // every output reads 0 during reset even with requests pending.
    always_comb begin
        pick_instr = 1'b0;
        pick_data  = 1'b0;
        if (rstn_i && (state_q == ST_IDLE)) begin
            if (instr_req_i && data_req_i) begin
                if (last_q == OWN_DATA) begin
                    pick_instr = 1'b1;
                end else begin
                    pick_data  = 1'b1;
                end
            end else begin
                pick_instr = instr_req_i;
                pick_data  = data_req_i;
            end
        end
    end

    // done has priority over the watchdog when both occur in the same cycle
    assign wait_done    = (state_q == ST_WAIT) && mem_done_i;
    assign wait_timeout = (state_q == ST_WAIT) && !mem_done_i && (wd_q == '0);

    // Next-state logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_instr || pick_data) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_done || wait_timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, owner tracking and round-robin pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INSTR;
            last_q  <= OWN_DATA;
        end else begin
            state_q <= state_d;
            if (pick_instr) begin
                owner_q <= OWN_INSTR;
                last_q  <= OWN_INSTR;
            end else if (pick_data) begin
                owner_q <= OWN_DATA;
                last_q  <= OWN_DATA;
            end
        end
    end

    // Latch the granted request; fields stay put until the next grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            funct_q <= '0;
        end else if (pick_instr) begin
            we_q    <= 1'b0;
            be_q    <= 4'b1111;
            addr_q  <= instr_addr_i;
            wdata_q <= '0;
            funct_q <= FUNCT_NULL;
        end else if (pick_data) begin
            we_q    <= data_we_i;
            be_q    <= data_be_i;
            addr_q  <= data_addr_i;
            wdata_q <= data_wdata_i;
            funct_q <= data_funct_i;
        end
    end

    // Watchdog: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wd_q <= WD_LOAD;
        end else if ((state_q == ST_WAIT) && (wd_q != '0)) begin
            wd_q <= wd_q - 1'b1;
        end
    end

    // Capture the completion result straight into the owner's rdata
    // register, which then holds until that port's next response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q         <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else if (wait_done || wait_timeout) begin
            err_q <= wait_timeout;
            if (owner_q == OWN_INSTR) begin
                instr_rdata_q <= wait_done ? mem_rdata_i : '0;
            end else begin
                data_rdata_q  <= wait_done ? mem_rdata_i : '0;
            end
        end
    end

    assign instr_gnt_o    = pick_instr;
    assign data_gnt_o     = pick_data;
    assign instr_rvalid_o = (state_q == ST_RESP) && (owner_q == OWN_INSTR);
    assign data_rvalid_o  = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign err_o          = (state_q == ST_RESP) && err_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rdata_o   = data_rdata_q;

    assign mem_en_o    = (state_q == ST_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_funct_o = funct_q;

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_racetrack_port_arbiter.sv
// Bench for racetrack_port_arbiter: directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a transaction model
// that reasons in "cycles since grant" rather than controller states.

module tb_racetrack_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int T  = 8;
    localparam logic [7:0] FUNCT_NULL = 8'h00;
    localparam logic [7:0] FUNCT_AND  = 8'h01;

    logic          clk;
    logic          rstn;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [DW-1:0] instr_rdata;
    logic          data_req;
    logic          data_we;
    logic [3:0]    data_be;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [7:0]    data_funct;
    logic          data_gnt;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_funct;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // memory-side drivers: manual (directed) and automatic responder
    logic          done_man;
    logic [DW-1:0] man_rdata;
    logic          auto_en;
    logic          auto_done;
    logic [DW-1:0] auto_rdata;
    logic          en_seen;

    int vectors;
    int miscompares;

    assign mem_done  = done_man | auto_done;
    assign mem_rdata = auto_done ? auto_rdata : man_rdata;

    racetrack_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (10),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .instr_req_i   (instr_req),
        .instr_addr_i  (instr_addr),
        .instr_gnt_o   (instr_gnt),
        .instr_rvalid_o(instr_rvalid),
        .instr_rdata_o (instr_rdata),
        .data_req_i    (data_req),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_funct_i  (data_funct),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_rdata_o  (data_rdata),
        .err_o         (err),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_funct_o   (mem_funct),
        .mem_done_i    (mem_done),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Automatic responder: completes each access in the cycle after mem_en.
    always @(negedge clk) en_seen = mem_en;
    always @(posedge clk) begin
        #1;
        auto_done  = auto_en & en_seen;
        auto_rdata = {10'h0, mem_addr} ^ 32'hA5A5_0000;
    end

    // ---------------- transaction model ----------------
    logic          m_busy;
    int            m_age;
    logic          m_owner;
    logic          m_last;
    logic          m_resp;
    logic          m_err;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [7:0]    m_funct;
    logic [DW-1:0] m_rd_i;
    logic [DW-1:0] m_rd_d;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_owner = 0; m_last = 1; m_resp = 0; m_err = 0;
        m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_funct = '0;
        m_rd_i = '0; m_rd_d = '0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic e_gi, e_gd, e_ri, e_rd, e_err, e_en;
        if (!rstn) model_reset();
        e_gi = 0; e_gd = 0; e_ri = 0; e_rd = 0; e_err = 0; e_en = 0;
        if (rstn && !m_busy) begin
            if (instr_req && (!data_req || m_last)) e_gi = 1;
            else if (data_req) e_gd = 1;
        end else if (m_busy) begin
            e_en = (m_age == 1);
            if (m_resp) begin
                if (m_owner) e_rd = 1; else e_ri = 1;
                e_err = m_err;
            end
        end
        chk("m_instr_gnt", instr_gnt, e_gi);
        chk("m_data_gnt", data_gnt, e_gd);
        chk("m_instr_rvalid", instr_rvalid, e_ri);
        chk("m_data_rvalid", data_rvalid, e_rd);
        chk("m_err", err, e_err);
        chk("m_mem_en", mem_en, e_en);
        chk("m_busy", busy, m_busy);
        chk("m_fields", {mem_we, mem_be, mem_funct}, {m_we, m_be, m_funct});
        chk("m_addr", mem_addr, m_addr);
        chk("m_wdata", mem_wdata, m_wdata);
        chk("m_instr_rdata", instr_rdata, m_rd_i);
        chk("m_data_rdata", data_rdata, m_rd_d);
        if (rstn) begin
            if (!m_busy) begin
                if (e_gi) begin
                    m_busy = 1; m_age = 1; m_owner = 0; m_last = 0;
                    m_we = 0; m_be = 4'hF; m_funct = FUNCT_NULL; m_wdata = '0; m_addr = instr_addr;
                end else if (e_gd) begin
                    m_busy = 1; m_age = 1; m_owner = 1; m_last = 1;
                    m_we = data_we; m_be = data_be; m_funct = data_funct;
                    m_wdata = data_wdata; m_addr = data_addr;
                end
            end else if (m_resp) begin
                m_busy = 0; m_resp = 0;
            end else begin
                if (m_age >= 2 && mem_done) begin
                    m_resp = 1; m_err = 0;
                    if (m_owner) m_rd_d = mem_rdata; else m_rd_i = mem_rdata;
                end else if (m_age == 2 + T) begin
                    m_resp = 1; m_err = 1;
                    if (m_owner) m_rd_d = '0; else m_rd_i = '0;
                end
                m_age++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int gseq[$];
        int eaddr[$];
        int iv, dv, dg;
        logic drop_i, drop_d;

        vectors = 0; miscompares = 0;
        rstn = 0; instr_req = 0; instr_addr = '0;
        data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0; data_funct = '0;
        done_man = 0; man_rdata = '0; auto_en = 0; auto_done = 0; auto_rdata = '0; en_seen = 0;

        // reset state
        step(); step();
        samp();
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_instr_rdata", instr_rdata, 0);
        step(); rstn = 1;

        // single fetch: gnt c0, mem_en c1, done c3, rvalid c4
        step(); instr_req = 1; instr_addr = 22'h10;
        samp(); chk("t1_gnt", instr_gnt, 1);
        step(); instr_req = 0;
        samp(); chk("t1_en", mem_en, 1); chk("t1_addr", mem_addr, 22'h10); chk("t1_funct", mem_funct, FUNCT_NULL);
        step();
        step(); done_man = 1; man_rdata = 32'hDEADBEEF;
        step(); done_man = 0;
        samp(); chk("t1_rvalid", instr_rvalid, 1); chk("t1_rdata", instr_rdata, 32'hDEADBEEF); chk("t1_err", err, 0);
        step();

        // tie and round-robin from reset
        rstn = 0;
        step(); step();
        rstn = 1; auto_en = 1;
        instr_req = 1; instr_addr = 22'h100;
        data_req = 1; data_addr = 22'h200; data_be = 4'hF;
        for (int i = 0; i < 16; i++) begin
            samp();
            if (instr_gnt) gseq.push_back(0);
            if (data_gnt) gseq.push_back(1);
            if (mem_en) eaddr.push_back(int'(mem_addr));
            step();
        end
        instr_req = 0; data_req = 0;
        chk("rr_ngrants", gseq.size(), 4);
        chk("rr_nen", eaddr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gseq.size()) chk("rr_order", gseq[i], i % 2);
            if (i < eaddr.size()) chk("rr_addr", eaddr[i], (i % 2) ? 32'h200 : 32'h100);
        end
        auto_en = 0;
        step(); step();

        // data LiM write
        data_req = 1; data_we = 1; data_be = 4'b0011; data_funct = FUNCT_AND;
        data_wdata = 32'h1234; data_addr = 22'h55;
        samp(); chk("t3_gnt", data_gnt, 1); chk("t3_igt", instr_gnt, 0);
        step(); data_req = 0;
        for (int c = 1; c <= 3; c++) begin
            samp();
            chk("t3_fields", {mem_we, mem_be, mem_funct}, {1'b1, 4'b0011, FUNCT_AND});
            chk("t3_wdata", mem_wdata, 32'h1234);
            chk("t3_en", mem_en, (c == 1));
            step();
            if (c == 2) begin done_man = 1; man_rdata = 32'h0BADF00D; end
        end
        done_man = 0;
        samp(); chk("t3_drv", data_rvalid, 1); chk("t3_irv", instr_rvalid, 0);
        chk("t3_rdata", data_rdata, 32'h0BADF00D);
        step(); data_we = 0; data_be = 4'hF; data_funct = FUNCT_NULL; data_wdata = '0;

        // timeout: gnt c0, error response c11
        instr_req = 1; instr_addr = 22'h77;
        samp(); chk("t4_gnt", instr_gnt, 1);
        step(); instr_req = 0;
        repeat (9) step();
        samp(); chk("t4_early", instr_rvalid, 0);
        step();
        samp(); chk("t4_rvalid", instr_rvalid, 1); chk("t4_err", err, 1); chk("t4_rdata", instr_rdata, 0);
        step(); done_man = 1; man_rdata = 32'hFFFFFFFF;
        samp(); chk("t4_late_busy", busy, 0); chk("t4_late_rv", instr_rvalid, 0);
        step(); done_man = 0; auto_en = 1; data_req = 1; data_addr = 22'h3A;
        samp(); chk("t4_next_gnt", data_gnt, 1);
        step(); data_req = 0;
        step(); step();
        samp(); chk("t4_next_rv", data_rvalid, 1); chk("t4_next_err", err, 0);
        chk("t4_next_rdata", data_rdata, 32'hA5A5003A);
        step(); auto_en = 0;

        // done and timeout in the same cycle (c10)
        instr_req = 1; instr_addr = 22'h99;
        samp(); chk("t5_gnt", instr_gnt, 1);
        step(); instr_req = 0;
        repeat (9) step();
        done_man = 1; man_rdata = 32'h600DCAFE;
        samp(); chk("t5_busy", busy, 1);
        step(); done_man = 0;
        samp(); chk("t5_rv", instr_rvalid, 1); chk("t5_err", err, 0); chk("t5_rdata", instr_rdata, 32'h600DCAFE);
        step();

        // asynchronous reset during WAIT
        instr_req = 1; instr_addr = 22'h2A;
        samp(); chk("t6_gnt", instr_gnt, 1);
        step(); instr_req = 0;
        step(); step();
        #2 rstn = 0;
        #1;
        chk("t6_busy", busy, 0); chk("t6_addr", mem_addr, 0); chk("t6_rdata", instr_rdata, 0);
        chk("t6_fields", {mem_we, mem_be, mem_funct, mem_en, err}, 0);
        instr_req = 1; data_req = 1; data_addr = 22'h2B;
        samp(); chk("t6_gnt_in_rst", {instr_gnt, data_gnt}, 0); chk("t6_rv", {instr_rvalid, data_rvalid}, 0);
        step(); done_man = 1;
        step(); done_man = 0; rstn = 1;
        samp(); chk("t6_tie_i", instr_gnt, 1); chk("t6_tie_d", data_gnt, 0);
        step(); instr_req = 0; auto_en = 1;
        iv = 0; dv = 0; dg = 0;
        for (int i = 0; i < 12; i++) begin
            samp();
            iv += int'(instr_rvalid);
            dv += int'(data_rvalid);
            dg += int'(data_gnt);
            drop_d = data_gnt;
            step();
            if (drop_d) data_req = 0;
        end
        chk("t6_ivalid_cnt", iv, 1);
        chk("t6_dvalid_cnt", dv, 1);
        chk("t6_dgnt_cnt", dg, 1);
        auto_en = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
